// File: rtl/imem_load_ctrl.sv
// Instruction memory sequencer: clears the array, streams in a program
// image over a valid/ready port, then hands the array to instruction fetch.
module imem_load_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [31:0]   pc,
    output logic [DW-1:0] instr,
    output logic          addr_err,
    output logic          cpu_stall,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          load_done,
    output logic          load_ovf,
    output logic [AW:0]   load_count,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] clr_cnt;
    logic          clr_end;
    logic          last_slot;
    logic          pc_bad;

    assign clr_end   = (clr_cnt == AW'(DEPTH - 1));
    assign last_slot = (load_count[AW-1:0] == AW'(DEPTH - 1));
    assign pc_bad    = (|pc[1:0]) | (|pc[31:AW+2]);
    assign cpu_stall = (state != RUN);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            load_count <= '0;
            load_done  <= 1'b0;
            load_ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_end) begin
                        load_count <= '0;
                        load_ovf   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        load_count <= load_count + (AW+1)'(1);
                        if (ld_last || last_slot) begin
                            load_done <= 1'b1;
                            load_ovf  <= ~ld_last;
                        end
                    end
                end
                RUN: begin
                    if (ld_start) begin
                        load_done <= 1'b0;
                        clr_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ld_ready  = 1'b0;
        instr     = '0;
        addr_err  = 1'b0;
        unique case (state)
            CLEAR: begin
                // Held off while reset is asserted so the array is untouched
                mem_we   = RESET;
                mem_addr = clr_cnt;
                if (clr_end)
                    state_nx = IDLE;
            end
            IDLE: begin
                if (ld_start)
                    state_nx = LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_addr  = load_count[AW-1:0];
                    mem_wdata = ld_data;
                    if (ld_last || last_slot)
                        state_nx = RUN;
                end
            end
            RUN: begin
                mem_addr = pc[AW+1:2];
                addr_err = pc_bad;
                instr    = pc_bad ? '0 : mem_rdata;
                if (ld_start)
                    state_nx = CLEAR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: vector table for fetch decode, randomized
// loads and fetches checked against an image-level model of the memory.
module tb_imem_load_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 32;

    logic          CLK;
    logic          RESET;
    logic [31:0]   pc;
    logic [DW-1:0] instr;
    logic          addr_err;
    logic          cpu_stall;
    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          load_done;
    logic          load_ovf;
    logic [AW:0]   load_count;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    imem_load_ctrl dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .pc         (pc),
        .instr      (instr),
        .addr_err   (addr_err),
        .cpu_stall  (cpu_stall),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .load_done  (load_done),
        .load_ovf   (load_ovf),
        .load_count (load_count),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port memory the controller sequences
    logic [DW-1:0] mem [DEPTH];
    always @(posedge CLK)
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Image-level model: what each word should hold after the last load
    logic [DW-1:0] exp_img [DEPTH];
    logic [DW-1:0] img [DEPTH];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk_reset();
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_load_ovf", 32'(load_ovf), 0);
        chk("rst_load_count", 32'(load_count), 0);
        chk("rst_ld_ready", 32'(ld_ready), 0);
        chk("rst_cpu_stall", 32'(cpu_stall), 1);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_instr", instr, 0);
        chk("rst_addr_err", 32'(addr_err), 0);
    endtask

    task automatic model_wipe();
        for (int i = 0; i < DEPTH; i++)
            exp_img[i] = '0;
    endtask

    // Starts at a negedge in the first CLEAR cycle; ends at a negedge in IDLE
    task automatic clear_check(input bit poke_start);
        for (int i = 0; i < DEPTH; i++) begin
            ld_start = poke_start && (i == 20);
            #1;
            chk("clr_mem_we", 32'(mem_we), 1);
            chk("clr_mem_addr", 32'(mem_addr), 32'(i));
            chk("clr_mem_wdata", mem_wdata, 0);
            chk("clr_cpu_stall", 32'(cpu_stall), 1);
            chk("clr_ld_ready", 32'(ld_ready), 0);
            step();
        end
        ld_start = 1'b0;
        model_wipe();
        #1;
        chk("idle_ld_ready", 32'(ld_ready), 0);
        chk("idle_mem_we", 32'(mem_we), 0);
        chk("idle_load_count", 32'(load_count), 0);
        chk("idle_load_ovf", 32'(load_ovf), 0);
        chk("idle_cpu_stall", 32'(cpu_stall), 1);
    endtask

    task automatic idle_hold(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("wait_stall", 32'(cpu_stall), 1);
            chk("wait_ld_ready", 32'(ld_ready), 0);
            step();
        end
    endtask

    // From RUN: request reload, walk the full clear, leave in IDLE
    task automatic reload(input logic [AW:0] held_count);
        ld_start = 1'b1;
        #1;
        step();
        ld_start = 1'b0;
        #1;
        chk("rl_cpu_stall", 32'(cpu_stall), 1);
        chk("rl_load_done", 32'(load_done), 0);
        chk("rl_count_held", 32'(load_count), 32'(held_count));
        clear_check(1'b1);
        step();
        idle_hold(3);
    endtask

    // From IDLE: stream img[0..n-1]; abort_at >= 0 stops after that many words
    task automatic load_image(input int n, input bit use_last,
                              input int mingap, input int maxgap,
                              input int abort_at);
        pc       = 32'h103;
        ld_start = 1'b1;
        #1;
        chk("ld_idle_ready", 32'(ld_ready), 0);
        step();
        ld_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k == abort_at)
                break;
            if (k > 0) begin
                int g;
                g = $urandom_range(maxgap, mingap);
                for (int j = 0; j < g; j++) begin
                    ld_valid = 1'b0;
                    ld_data  = $urandom;
                    ld_last  = 1'($urandom);
                    #1;
                    chk("gap_ld_ready", 32'(ld_ready), 1);
                    chk("gap_mem_we", 32'(mem_we), 0);
                    chk("gap_addr_err", 32'(addr_err), 0);
                    step();
                end
            end
            ld_valid = 1'b1;
            ld_data  = img[k];
            ld_last  = use_last && (k == n - 1);
            #1;
            chk("xf_ld_ready", 32'(ld_ready), 1);
            chk("xf_mem_we", 32'(mem_we), 1);
            chk("xf_mem_addr", 32'(mem_addr), 32'(k));
            chk("xf_mem_wdata", mem_wdata, img[k]);
            chk("xf_cpu_stall", 32'(cpu_stall), 1);
            exp_img[k] = img[k];
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (abort_at < 0) begin
            #1;
            chk("end_cpu_stall", 32'(cpu_stall), 0);
            chk("end_load_done", 32'(load_done), 1);
            chk("end_load_count", 32'(load_count), 32'(n));
            chk("end_load_ovf", 32'(load_ovf),
                32'((n == DEPTH) && !use_last));
            chk("end_ld_ready", 32'(ld_ready), 0);
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        bit err;
        err = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 0);
        pc  = a;
        #1;
        chk("f_addr_err", 32'(addr_err), 32'(err));
        chk("f_instr", instr, err ? 32'h0 : exp_img[a[AW+1:2]]);
        if (!err)
            chk("f_mem_addr", 32'(mem_addr), 32'(a[AW+1:2]));
        step();
    endtask

    task automatic rand_fetch(input int n);
        for (int i = 0; i < n; i++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(9, 0);
            a = {24'h0, 6'($urandom_range(DEPTH - 1, 0)), 2'b00};
            if (r == 7)
                a = a + 32'($urandom_range(3, 1));
            else if (r > 7)
                a = $urandom | 32'h100;
            fetch(a);
        end
    endtask

    initial begin
        tbl[0] = '{32'h8,        32'h01095020, 1'b0};
        tbl[1] = '{32'h0,        32'h20080005, 1'b0};
        tbl[2] = '{32'h4,        32'h20090003, 1'b0};
        tbl[3] = '{32'hC,        32'h0,        1'b0};
        tbl[4] = '{32'hFC,       32'h0,        1'b0};
        tbl[5] = '{32'h100,      32'h0,        1'b1};
        tbl[6] = '{32'h6,        32'h0,        1'b1};
        tbl[7] = '{32'h80000000, 32'h0,        1'b1};

        RESET    = 1'b1;
        pc       = 32'h3;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        model_wipe();

        // Power-up reset and first clear
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk_reset();
        step();
        step();
        step();
        #1;
        chk_reset();
        RESET = 1'b1;
        clear_check(1'b0);
        step();
        idle_hold(2);

        // Three-word program with two idle cycles between words
        img[0] = 32'h20080005;
        img[1] = 32'h20090003;
        img[2] = 32'h01095020;
        load_image(3, 1'b1, 2, 2, -1);

        for (int i = 0; i < 8; i++) begin
            pc = tbl[i].pc;
            #1;
            chk("tbl_instr", instr, tbl[i].instr);
            chk("tbl_addr_err", 32'(addr_err), 32'(tbl[i].err));
            if (!tbl[i].err)
                chk("tbl_mem_addr", 32'(mem_addr), 32'(tbl[i].pc[7:2]));
            step();
        end

        // Reload with an ignored ld_start mid-clear, then overflow load
        reload(3);
        for (int i = 0; i < DEPTH; i++)
            img[i] = $urandom;
        load_image(DEPTH, 1'b0, 0, 3, -1);
        rand_fetch(24);
        step();
        #1;
        chk("ovf_held", 32'(load_ovf), 1);
        chk("ovf_count_held", 32'(load_count), 64);
        chk("ovf_ready", 32'(ld_ready), 0);

        // Random images of random length
        begin
            int prev;
            prev = DEPTH;
            for (int t = 0; t < 4; t++) begin
                int n;
                n = $urandom_range(DEPTH, 1);
                reload(7'(prev));
                for (int i = 0; i < DEPTH; i++)
                    img[i] = $urandom;
                load_image(n, 1'b1, 0, 2, -1);
                rand_fetch(16);
                prev = n;
            end
            reload(7'(prev));
        end

        // Reset in the middle of a load discards the partial image
        for (int i = 0; i < DEPTH; i++)
            img[i] = $urandom;
        load_image(30, 1'b1, 0, 2, 10);
        RESET = 1'b0;
        #1;
        chk_reset();
        step();
        step();
        RESET = 1'b1;
        clear_check(1'b0);
        step();
        idle_hold(5);
        for (int i = 0; i < DEPTH; i++)
            img[i] = $urandom;
        load_image(4, 1'b1, 0, 1, -1);
        for (int i = 0; i < 12; i++)
            fetch(32'(i * 4));
        rand_fetch(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Sequences the single-port 64-word instruction memory of the single-cycle MIPS core.
- On reset it clears the array to zero (NOP), then accepts a program image streamed word by word over a valid/ready loader port, then hands the array to the fetch path.
- While it owns the array, it holds the CPU stalled. A reload can be started from RUN at any time.

Parameters:
DEPTH, 64, number of 32-bit instruction words
AW, 6, word-address width (log2 DEPTH)
DW, 32, instruction width

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  asynchronous active-low reset
pc  in  32  byte address from PC register
instr  out  DW  instruction to decoder
addr_err  out  1  fetch address misaligned or out of range
cpu_stall  out  1  CPU must hold PC
ld_start  in  1  request (re)load; pulse
ld_valid  in  1  loader word valid
ld_data  in  DW  loader word
ld_last  in  1  qualifies final word of image
ld_ready  out  1  controller accepts word
load_done  out  1  image loaded, RUN active
load_ovf  out  1  image filled DEPTH words without ld_last
load_count  out  AW+1  words written in current load
mem_addr  out  AW  memory word address
mem_we  out  1  memory write enable (memory writes on rising CLK)
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory combinational read data

Behaviour:
- States: CLEAR, IDLE, LOAD, RUN. RESET low forces CLEAR immediately and asynchronously, with the clear counter at 0.
- Reset values: load_done=0, load_ovf=0, load_count=0, ld_ready=0, cpu_stall=1, mem_we=0, instr=0, addr_err=0.
- cpu_stall = (state != RUN). This signal is combinational from state.
- CLEAR:
  - mem_we=1, mem_addr=clear counter, mem_wdata=0.
  - The counter runs 0..DEPTH-1, one word per cycle, so CLEAR lasts exactly DEPTH cycles.
  - After the write to DEPTH-1: go to IDLE, load_count=0, load_ovf=0.
  - ld_start is ignored in this state.
- IDLE:
  - ld_ready=0, mem_we=0.
  - ld_start=1 -> LOAD on the next edge. ld_valid is ignored.
- LOAD:
  - ld_ready=1.
  - A transfer occurs when ld_valid & ld_ready. In that same cycle: mem_we=1, mem_addr=load_count[AW-1:0], mem_wdata=ld_data. load_count increments at the edge.
  - Cycles with no transfer: mem_we=0.
  - Transfer with ld_last=1 -> RUN on the next edge, load_done=1.
  - Transfer to address DEPTH-1 with ld_last=0 -> RUN on the next edge, load_done=1, load_ovf=1. load_count ends at DEPTH and further ld_valid is not accepted (ld_ready=0).
  - ld_start is ignored in this state.
- RUN:
  - mem_we=0, ld_ready=0, mem_addr=pc[AW+1:2].
  - instr = mem_rdata combinationally, giving zero-cycle fetch latency.
  - addr_err=1 when pc[1:0]!=0 or pc[31:AW+2]!=0. In that case instr=0 (NOP); addr_err is combinational.
  - ld_start=1 -> CLEAR on the next edge. load_done clears on entering CLEAR. load_count is held until CLEAR completes, then zeroed.
- Outside RUN: instr=0, addr_err=0.
- mem_addr outside the cases above is don't-care, but it must be driven to a known value; drive 0.
- load_ovf and load_count are held through RUN until the next CLEAR completes.
- RESET asserted mid-LOAD or mid-CLEAR: the partial image is discarded and the full CLEAR sequence reruns after release.

Test Plan:
1. RESET low 3 cycles, then high -> RESET low: all outputs at reset values. After release: 64 cycles of mem_we=1, mem_addr 0..63, mem_wdata=0, cpu_stall=1 throughout. Then IDLE with ld_ready=0.
2. Normal load:
   - Stimulus: in IDLE, pulse ld_start. Send 0x20080005, 0x20090003, 0x01095020, with ld_valid low for 2 cycles between words and ld_last on the third.
   - Response: writes to addresses 0,1,2 only during valid cycles. load_count=3, RUN on the next edge, load_done=1, cpu_stall=0, load_ovf=0.
3. Fetch in RUN:
   - pc=0x8 -> mem_addr=2, instr=0x01095020, addr_err=0.
   - pc=0x100 -> instr=0, addr_err=1.
   - pc=0x6 -> instr=0, addr_err=1.
4. Overflow: load 64 words with ld_last never set -> after the 64th write, RUN, load_count=64, load_ovf=1, ld_ready=0.
5. Reload: ld_start in RUN -> next cycle cpu_stall=1, load_done=0, CLEAR of 64 words. A second ld_start during CLEAR is ignored, and the controller waits in IDLE.
6. Reset mid-load: RESET low after 10 words are accepted -> outputs go to reset values immediately without waiting for CLK. After release, the full CLEAR reruns, and an ld_start pulse after CLEAR completes is required to load again.
